// File: rtl/shift_seq_ctrl_pkg.sv
// rtl/shift_seq_ctrl_pkg.sv - shared op encodings and FSM state type for the sequential shifter
// Contents:
//   shift_op_e : OP_SLL / OP_SRL / OP_SRA / OP_RSV, the 2-bit op field also used by the ALU decoder
//   state_e    : S_IDLE / S_RUN controller states
package shift_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_RSV = 2'b11
    } shift_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// rtl/shift_seq_ctrl_if.sv - start/busy/done request and result bundle of the sequential shifter
// Signals:
//   start, op[1:0], a[WIDTH-1:0], shamt[SHW-1:0] : request side, driven by the master
//   busy, done, result[WIDTH-1:0], err           : status side, driven by the slave (shifter)
interface shift_seq_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int SHW   = 8
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;

    modport master (
        output start, op, a, shamt,
        input  busy, done, result, err
    );

    modport slave (
        input  start, op, a, shamt,
        output busy, done, result, err
    );
endinterface

// File: rtl/shift_seq_ctrl_shift1_step.sv
// rtl/shift_seq_ctrl_shift1_step.sv - combinational single-bit shift step
// Ports:
//   in_data  in  WIDTH  value to shift
//   op       in  2      shift kind (SLL / SRL / SRA; reserved passes through)
//   out_data out  WIDTH  in_data shifted by exactly one bit
module shift1_step
    import shift_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in_data,
    input  shift_op_e        op,
    output logic [WIDTH-1:0] out_data
);
    always_comb begin
        out_data = in_data;
        case (op)
            OP_SLL:  out_data = {in_data[WIDTH-2:0], 1'b0};
            OP_SRL:  out_data = {1'b0, in_data[WIDTH-1:1]};
            OP_SRA:  out_data = {in_data[WIDTH-1], in_data[WIDTH-1:1]};
            default: out_data = in_data;
        endcase
    end
endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - sequential SLL/SRL/SRA unit, one bit per cycle under a down-counter
// Ports:
//   clk  in  clock, all state on posedge
//   rst  in  synchronous active-high reset; aborts any operation without a done
//   bus  slave modport of shift_seq_ctrl_if (start/op/a/shamt in, busy/done/result/err out)
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = 8
) (
    input  logic           clk,
    input  logic           rst,
    shift_seq_ctrl_if.slave bus
);
    // One extra bit so the counter can hold WIDTH itself (saturated amount).
    localparam int CW = $clog2(WIDTH) + 1;

    state_e           state_q, state_d;
    shift_op_e        op_q, op_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [CW-1:0]    eff;
    logic [WIDTH-1:0] step_out;

    shift1_step #(.WIDTH(WIDTH)) u_step (
        .in_data  (sreg_q),
        .op       (op_q),
        .out_data (step_out)
    );

    // Amounts of WIDTH or more all behave like WIDTH steps, which fully
    // drains SLL/SRL to zero and fills SRA with the sign bit.
    always_comb begin
        eff = '0;
        if (bus.shamt >= SHW'(WIDTH))
            eff = CW'(WIDTH);
        else
            eff = bus.shamt[CW-1:0];
        if (shift_op_e'(bus.op) == OP_RSV)
            eff = '0;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sreg_d   = sreg_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sreg_d  = bus.a;
                    op_d    = shift_op_e'(bus.op);
                    cnt_d   = eff;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q != '0) begin
                    sreg_d = step_out;
                    cnt_d  = cnt_q - 1'b1;
                end else begin
                    result_d = sreg_q;
                    done_d   = 1'b1;
                    err_d    = (op_q == OP_RSV);
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_SLL;
            sreg_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sreg_q   <= sreg_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.busy   = (state_q == S_RUN);
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - self-checking bench for shift_seq_ctrl against a behavioural shift model
module tb_shift_seq_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   asserts = 0;
    int   fails   = 0;
    logic [W-1:0] exp_result = '0;

    always #5 clk = ~clk;

    shift_seq_ctrl_if #(.WIDTH(W), .SHW(8)) bus ();

    shift_seq_ctrl #(.WIDTH(W), .SHW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [W-1:0] model_shift(logic [1:0] o, logic [W-1:0] x, logic [7:0] s);
        int n;
        logic [W-1:0] r;
        n = (int'(s) >= W) ? W : int'(s);
        case (o)
            2'd0:    r = (n >= W) ? '0 : (x << n);
            2'd1:    r = (n >= W) ? '0 : (x >> n);
            2'd2:    r = W'($signed(x) >>> n);
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic int model_lat(logic [1:0] o, logic [7:0] s);
        if (o == 2'd3) return 1;
        return ((int'(s) >= W) ? W : int'(s)) + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller is #1 after an edge; request is sampled on the next edge.
    task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [7:0] s);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.shamt = s;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.shamt = 8'($urandom);
        bus.op    = 2'($urandom);
        chk("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    task automatic wait_done(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                             input logic [7:0] s, input bit noise);
        int n;
        logic [W-1:0] er;
        n  = 0;
        er = model_shift(o, x, s);
        while (bus.done !== 1'b1 && n < W + 4) begin
            if (noise && n < 3) begin
                bus.start = 1'b1;
                bus.a     = W'($urandom);
                bus.shamt = 8'($urandom_range(0, 3));
                bus.op    = 2'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (bus.done !== 1'b1)
                chk({tag, "_held"}, 32'(bus.result), 32'(exp_result));
        end
        bus.start = 1'b0;
        exp_result = er;
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_lat"}, 32'(n), 32'(model_lat(o, s)));
        chk({tag, "_res"}, 32'(bus.result), 32'(er));
        chk({tag, "_err"}, 32'(bus.err), 32'(o == 2'd3));
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic idle_cycle(input string tag);
        @(posedge clk); #1;
        chk({tag, "_idle_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_idle_err"}, 32'(bus.err), 32'd0);
        chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_idle_res"}, 32'(bus.result), 32'(exp_result));
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [W-1:0] x, input logic [7:0] s);
        launch(o, x, s);
        wait_done(tag, o, x, s, 1'b0);
        idle_cycle(tag);
    endtask

    initial begin
        int saw_done;
        logic [1:0] ro;
        logic [W-1:0] ra;
        logic [7:0] rs;

        rst = 1'b1; bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.shamt = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        rst = 1'b0;

        // Reset in the middle of a run clears a previously nonzero result.
        run("pre", 2'd1, 8'hF0, 8'd2);
        launch(2'd0, 8'hFF, 8'd5);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        exp_result = '0;
        chk("rst2_busy", 32'(bus.busy), 32'd0);
        chk("rst2_done", 32'(bus.done), 32'd0);
        chk("rst2_result", 32'(bus.result), 32'd0);
        launch(2'd0, 8'b10110101, 8'd3);
        wait_done("t1_sll3", 2'd0, 8'b10110101, 8'd3, 1'b0);
        chk("t1_const", 32'(bus.result), 32'(8'b10101000));
        idle_cycle("t1");

        for (int n = 0; n <= 8; n++)
            run("t2_sll", 2'd0, 8'b10110101, 8'(n));

        run("t3_sll98", 2'd0, 8'b10110101, 8'd98);
        chk("t3_sll98_zero", 32'(bus.result), 32'h00);
        run("t3_sra200", 2'd2, 8'h80, 8'd200);
        chk("t3_sra200_ff", 32'(bus.result), 32'hFF);

        run("t4_sra2", 2'd2, 8'b10110101, 8'd2);
        chk("t4_sra2_const", 32'(bus.result), 32'(8'b11101101));
        run("t4_srl2", 2'd1, 8'b10110101, 8'd2);
        chk("t4_srl2_const", 32'(bus.result), 32'(8'b00101101));

        // Starts during the run are ignored; then back-to-back on the done cycle.
        launch(2'd1, 8'hC3, 8'd5);
        wait_done("t5_noise", 2'd1, 8'hC3, 8'd5, 1'b1);
        launch(2'd2, 8'h96, 8'd1);
        wait_done("t5_b2b", 2'd2, 8'h96, 8'd1, 1'b0);
        idle_cycle("t5");

        run("t6_rsv", 2'd3, 8'h5A, 8'd4);
        chk("t6_rsv_const", 32'(bus.result), 32'h5A);

        launch(2'd0, 8'h3C, 8'd7);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_result = '0;
        chk("t6_abort_busy", 32'(bus.busy), 32'd0);
        chk("t6_abort_res", 32'(bus.result), 32'd0);
        saw_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) saw_done++;
        end
        chk("t6_abort_nodone", 32'(saw_done), 32'd0);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            ra = W'($urandom);
            rs = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
            launch(ro, ra, rs);
            wait_done("rnd", ro, ra, rs, 1'($urandom_range(0, 1)) & (model_lat(ro, rs) > 4));
            if ($urandom_range(0, 1) == 1) idle_cycle("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
